// File: rtl/boot_seq_pkg.sv
// Shared types and default constants for the boot sequencer.
// state_e encodings are exposed on state_o for debug; keep them stable.
package boot_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOAD  = 3'd1,
    CS_IDLE    = 3'd2,
    WAIT_FETCH = 3'd3,
    RUN        = 3'd4,
    DONE       = 3'd5
  } state_e;

  localparam int unsigned RST_DELAY_CYCLES_DEF = 16;
  localparam int unsigned CS_IDLE_CYCLES_DEF   = 64;
  localparam int unsigned WDT_CYCLES_DEF       = 65536;

  // Width of a saturating counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/boot_seq_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
// RESET_VAL selects the value both flops take while rst_n is low.
module boot_seq_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_seq_ctrl.sv
// Core start-up sequencer: holds core reset, optionally waits for an SPI
// L2 load followed by an idle chip-select period, then gates fetch_enable
// to the core and latches end-of-computation.
// Optional feature macro: BOOT_SEQ_WDT_EN (WAIT_LOAD/CS_IDLE watchdog with
// fallback to WAIT_FETCH and sticky timeout_o). Without it timeout_o is 0.
module boot_seq_ctrl
  import boot_seq_pkg::*;
#(
  parameter int unsigned RST_DELAY_CYCLES = RST_DELAY_CYCLES_DEF,
  parameter int unsigned CS_IDLE_CYCLES   = CS_IDLE_CYCLES_DEF,
  parameter int unsigned WDT_CYCLES       = WDT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       boot_mode_i,
  input  logic       load_done_i,
  input  logic       spi_cs_i,
  input  logic       fetch_enable_i,
  input  logic       eoc_i,
  output logic       core_rst_no,
  output logic       fetch_enable_o,
  output logic       eoc_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned RST_W  = cnt_width(RST_DELAY_CYCLES);
  localparam int unsigned IDLE_W = cnt_width(CS_IDLE_CYCLES);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_DELAY_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(CS_IDLE_CYCLES - 1);

  state_e            state;
  logic [RST_W-1:0]  rst_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              core_rst_q;
  logic              fetch_en_q;
  logic              eoc_q;
  logic              cs_sync;
  logic              fe_sync;

  boot_seq_sync #(
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_cs_i),
    .q     (cs_sync)
  );

  boot_seq_sync #(
    .RESET_VAL (1'b0)
  ) u_fe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fetch_enable_i),
    .q     (fe_sync)
  );

`ifdef BOOT_SEQ_WDT_EN
  localparam int unsigned       WDT_W    = cnt_width(WDT_CYCLES);
  localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout_q;
  logic             wdt_active;
  logic             wdt_fire;

  assign wdt_active = (state == WAIT_LOAD) || (state == CS_IDLE);
  assign wdt_fire   = wdt_active && (wdt_cnt == WDT_LAST);
  assign timeout_o  = timeout_q;
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = (WDT_CYCLES == 0);
  assign timeout_o         = 1'b0;
`endif

  // Sequencer FSM with its counters and registered/sticky outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_HOLD;
      rst_cnt    <= '0;
      idle_cnt   <= '0;
      core_rst_q <= 1'b0;
      fetch_en_q <= 1'b0;
      eoc_q      <= 1'b0;
`ifdef BOOT_SEQ_WDT_EN
      wdt_cnt    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef BOOT_SEQ_WDT_EN
      // Counter stops at its last value on the firing edge; it is cleared
      // again when WAIT_LOAD is next entered.
      if (wdt_active && !wdt_fire) begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
`endif
      case (state)
        RESET_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt    <= '0;
            core_rst_q <= 1'b1;
            state      <= boot_mode_i ? WAIT_LOAD : WAIT_FETCH;
`ifdef BOOT_SEQ_WDT_EN
            wdt_cnt    <= '0;
`endif
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        WAIT_LOAD: begin
`ifdef BOOT_SEQ_WDT_EN
          if (wdt_fire) begin
            state     <= WAIT_FETCH;
            timeout_q <= 1'b1;
          end else
`endif
          if (load_done_i) begin
            state    <= CS_IDLE;
            idle_cnt <= '0;
          end
        end

        CS_IDLE: begin
`ifdef BOOT_SEQ_WDT_EN
          if (wdt_fire) begin
            state     <= WAIT_FETCH;
            timeout_q <= 1'b1;
          end else
`endif
          if (!cs_sync) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            state    <= WAIT_FETCH;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        WAIT_FETCH: begin
          if (fe_sync) begin
            state      <= RUN;
            fetch_en_q <= 1'b1;
          end
        end

        RUN: begin
          // EOC wins over a simultaneous fetch-enable drop.
          if (eoc_i) begin
            state <= DONE;
            eoc_q <= 1'b1;
          end else if (!fe_sync) begin
            state      <= WAIT_FETCH;
            fetch_en_q <= 1'b0;
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state      <= RESET_HOLD;
          rst_cnt    <= '0;
          idle_cnt   <= '0;
          core_rst_q <= 1'b0;
          fetch_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_no    = core_rst_q;
  assign fetch_enable_o = fetch_en_q;
  assign eoc_o          = eoc_q;
  assign state_o        = state;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Self-checking bench for boot_seq_ctrl: directed scenarios plus a random
// run, all compared each cycle against a behavioural reference model.
module tb_boot_seq_ctrl;

  localparam int RST_D = 16;
  localparam int CS_N  = 64;
  localparam int WDT_N = 1000;

  logic       clk            = 1'b0;
  logic       rst_n          = 1'b0;
  logic       boot_mode_i    = 1'b0;
  logic       load_done_i    = 1'b0;
  logic       spi_cs_i       = 1'b1;
  logic       fetch_enable_i = 1'b0;
  logic       eoc_i          = 1'b0;
  logic       core_rst_no;
  logic       fetch_enable_o;
  logic       eoc_o;
  logic       timeout_o;
  logic [2:0] state_o;
  logic [6:0] dut_vec;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  boot_seq_ctrl #(
    .RST_DELAY_CYCLES (RST_D),
    .CS_IDLE_CYCLES   (CS_N),
    .WDT_CYCLES       (WDT_N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boot_mode_i    (boot_mode_i),
    .load_done_i    (load_done_i),
    .spi_cs_i       (spi_cs_i),
    .fetch_enable_i (fetch_enable_i),
    .eoc_i          (eoc_i),
    .core_rst_no    (core_rst_no),
    .fetch_enable_o (fetch_enable_o),
    .eoc_o          (eoc_o),
    .timeout_o      (timeout_o),
    .state_o        (state_o)
  );

  assign dut_vec = {core_rst_no, fetch_enable_o, eoc_o, timeout_o, state_o};

  // Reference model: phase number, elapsed-cycle tallies and the pad values
  // as the sequencer sees them two cycles late.
  int m_phase, m_hold, m_idle, m_wdt;
  bit m_rst_no, m_fe, m_eoc, m_to;
  bit cs_p1, cs_p2, fe_p1, fe_p2;

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_idle = 0; m_wdt = 0;
    m_rst_no = 0; m_fe = 0; m_eoc = 0; m_to = 0;
    cs_p1 = 1; cs_p2 = 1; fe_p1 = 0; fe_p2 = 0;
  endtask

  task automatic model_edge();
    bit cs_seen, fe_seen, wdt_hit;
    cs_seen = cs_p2;
    fe_seen = fe_p2;
    cs_p2 = cs_p1; cs_p1 = spi_cs_i;
    fe_p2 = fe_p1; fe_p1 = fetch_enable_i;
    wdt_hit = 0;
`ifdef BOOT_SEQ_WDT_EN
    if (m_phase == 1 || m_phase == 2) begin
      m_wdt++;
      wdt_hit = (m_wdt >= WDT_N);
    end
`endif
    if (wdt_hit) begin
      m_phase = 3;
      m_to = 1;
    end else begin
      case (m_phase)
        0: begin
          m_hold++;
          if (m_hold == RST_D) begin
            m_rst_no = 1;
            m_phase = boot_mode_i ? 1 : 3;
            m_wdt = 0;
          end
        end
        1: if (load_done_i) begin m_phase = 2; m_idle = 0; end
        2: begin
          m_idle = cs_seen ? m_idle + 1 : 0;
          if (m_idle == CS_N) m_phase = 3;
        end
        3: if (fe_seen) begin m_phase = 4; m_fe = 1; end
        4: begin
          if (eoc_i) begin m_phase = 5; m_eoc = 1; end
          else if (!fe_seen) begin m_phase = 3; m_fe = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [2:0] ph;
    ph = m_phase[2:0];
    return {m_rst_no, m_fe, m_eoc, m_to, ph};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    boot_mode_i = 0; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
    do_reset();
    repeat (30) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (dut_vec !== 7'b0000_000) $display("FAIL reset_async got %b expected %b", dut_vec, 7'b0000_000);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (dut_vec !== 7'b0000_000) $display("FAIL reset_held got %b expected %b", dut_vec, 7'b0000_000);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_standalone();
    int rise_rst, rise_fe;
    boot_mode_i = 0; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
    do_reset();
    rise_rst = -1; rise_fe = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL t1_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
      else n_pass++;
      if (core_rst_no && rise_rst < 0) rise_rst = c;
      if (fetch_enable_o && rise_fe < 0) rise_fe = c;
    end
    n_total++;
    if (rise_rst !== RST_D) $display("FAIL t1_core_rst_rise got %0d expected %0d", rise_rst, RST_D);
    else n_pass++;
    n_total++;
    if (rise_fe !== RST_D + 1) $display("FAIL t1_fe_rise_held got %0d expected %0d", rise_fe, RST_D + 1);
    else n_pass++;
    n_total++;
    if (state_o !== 3'd4) $display("FAIL t1_state got %0d expected 4", state_o);
    else n_pass++;

    // Pad fetch enable raised together with the core reset release.
    fetch_enable_i = 0;
    do_reset();
    rise_rst = -1; rise_fe = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL t1b_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
      else n_pass++;
      if (core_rst_no && rise_rst < 0) begin rise_rst = c; fetch_enable_i = 1; end
      if (fetch_enable_o && rise_fe < 0) rise_fe = c;
    end
    n_total++;
    if (rise_fe - rise_rst !== 3) $display("FAIL t1b_fe_latency got %0d expected 3", rise_fe - rise_rst);
    else n_pass++;
  endtask

  task automatic test_spi_load();
    int lc, rise_fe;
    for (int it = 0; it < 3; it++) begin
      lc = (it == 0) ? 100 : $urandom_range(20, 150);
      boot_mode_i = 1; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
      do_reset();
      rise_fe = -1;
      for (int c = 1; c <= lc + CS_N + 10; c++) begin
        // A pulse while still in reset hold must be ignored.
        load_done_i = (c == lc) || (c == 5);
        tick();
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL t2_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
        else n_pass++;
        if (fetch_enable_o && rise_fe < 0) rise_fe = c;
      end
      load_done_i = 0;
      n_total++;
      if (rise_fe - lc !== CS_N + 1) $display("FAIL t2_fe_after_load got %0d expected %0d", rise_fe - lc, CS_N + 1);
      else n_pass++;
    end
  endtask

  task automatic test_cs_restart();
    int lc, d, rise_fe;
    for (int it = 0; it < 2; it++) begin
      lc = 30;
      d = (it == 0) ? 1 : $urandom_range(2, 6);
      boot_mode_i = 1; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
      do_reset();
      rise_fe = -1;
      for (int c = 1; c <= lc + d + CS_N + 50; c++) begin
        load_done_i = (c == lc);
        // Low pad cs lands in the synced view when the idle count is 40.
        spi_cs_i = !((c >= lc + 39) && (c <= lc + 38 + d));
        tick();
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL t3_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
        else n_pass++;
        if (fetch_enable_o && rise_fe < 0) rise_fe = c;
      end
      load_done_i = 0; spi_cs_i = 1;
      n_total++;
      if (rise_fe !== lc + d + CS_N + 41) $display("FAIL t3_fe_rise got %0d expected %0d", rise_fe, lc + d + CS_N + 41);
      else n_pass++;
    end
  endtask

  task automatic test_fe_drop();
    int s, d, low_cnt, eoc_cnt;
    for (int it = 0; it < 2; it++) begin
      s = 30;
      d = (it == 0) ? 10 : $urandom_range(1, 15);
      boot_mode_i = 0; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
      do_reset();
      low_cnt = 0; eoc_cnt = 0;
      for (int c = 1; c <= s + d + 8; c++) begin
        fetch_enable_i = !((c >= s) && (c <= s + d - 1));
        tick();
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL t4_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
        else n_pass++;
        if (c >= s && !fetch_enable_o) low_cnt++;
        if (eoc_o) eoc_cnt++;
      end
      n_total++;
      if (low_cnt !== d) $display("FAIL t4_low_cycles got %0d expected %0d", low_cnt, d);
      else n_pass++;
      n_total++;
      if (eoc_cnt !== 0 || state_o !== 3'd4) $display("FAIL t4_end got eoc_cycles=%0d state=%0d expected 0 and 4", eoc_cnt, state_o);
      else n_pass++;
    end
  endtask

  task automatic test_eoc_priority();
    int s, rise_rst;
    s = 25;
    boot_mode_i = 0; fetch_enable_i = 1; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
    do_reset();
    for (int c = 1; c <= s + 10; c++) begin
      fetch_enable_i = (c < s);
      eoc_i = (c == s + 2);
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL t5_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
      else n_pass++;
    end
    eoc_i = 0;
    n_total++;
    if ({state_o, eoc_o, fetch_enable_o} !== {3'd5, 1'b1, 1'b1})
      $display("FAIL t5_done got state=%0d eoc=%b fe=%b expected 5 1 1", state_o, eoc_o, fetch_enable_o);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (dut_vec !== 7'b0000_000) $display("FAIL t5_reset got %b expected %b", dut_vec, 7'b0000_000);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch_enable_i = 1;
    rise_rst = -1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL t5_rehold_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
      else n_pass++;
      if (core_rst_no && rise_rst < 0) rise_rst = c;
    end
    n_total++;
    if (rise_rst !== RST_D) $display("FAIL t5_rehold got %0d expected %0d", rise_rst, RST_D);
    else n_pass++;
  endtask

  task automatic test_wdt();
    boot_mode_i = 1; fetch_enable_i = 0; spi_cs_i = 1; load_done_i = 0; eoc_i = 0;
    do_reset();
`ifdef BOOT_SEQ_WDT_EN
    begin
      int hit;
      hit = -1;
      for (int c = 1; c <= RST_D + WDT_N + 50; c++) begin
        tick();
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL t6_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
        else n_pass++;
        if (state_o == 3'd3 && hit < 0) hit = c;
      end
      n_total++;
      if (hit !== RST_D + WDT_N) $display("FAIL t6_wdt_fire got %0d expected %0d", hit, RST_D + WDT_N);
      else n_pass++;
      n_total++;
      if (timeout_o !== 1'b1) $display("FAIL t6_timeout got %b expected 1", timeout_o);
      else n_pass++;
    end
`else
    for (int c = 1; c <= 5000; c++) begin
      tick();
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL t6_model cyc %0d got %b expected %b", c, dut_vec, model_vec());
      else n_pass++;
    end
    n_total++;
    if ({state_o, timeout_o} !== {3'd1, 1'b0}) $display("FAIL t6_no_wdt got state=%0d timeout=%b expected 1 0", state_o, timeout_o);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      boot_mode_i = 1'($urandom_range(0, 1));
      fetch_enable_i = 1'($urandom_range(0, 1));
      spi_cs_i = 1; eoc_i = 0; load_done_i = 0;
      do_reset();
      for (int c = 1; c <= 1500; c++) begin
        load_done_i = ($urandom_range(0, 39) == 0);
        spi_cs_i = ($urandom_range(0, 99) < 98);
        if ($urandom_range(0, 29) == 0) fetch_enable_i = ~fetch_enable_i;
        eoc_i = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 999) == 0) begin
          rst_n = 1'b0;
          model_reset();
          @(posedge clk); #1;
          rst_n = 1'b1;
          boot_mode_i = 1'($urandom_range(0, 1));
        end
        tick();
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL rand_model run %0d cyc %0d got %b expected %b", r, c, dut_vec, model_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_standalone();
    test_spi_load();
    test_cs_restart();
    test_fe_drop();
    test_eoc_priority();
    test_wdt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: bench did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
